dual_slope_datapath: RTL and testbench

Synchronous digital model of the analog half of the dual-slope ADC: integrator, phase counter and result register. It answers the conversion-control FSM's switch and enable outputs (`ch[2:0]`, `en_0`) with the status it waits on (`en_3`, `Vint_z`), and latches the converted count. The block sits between the FSM and the display/register stage, so the whole converter can be simulated and synthesised without analog parts.

---
 rtl/dual_slope_datapath.sv | 112 +++++++++++
 tb/tb_dual_slope_datapath.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dual_slope_datapath.sv
// Digital stand-in for the analog side of a dual-slope ADC: integrator, phase
// counter and result register, answering the conversion FSM's switch/enable lines.
module dual_slope_datapath #(
  parameter int N_BITS = 4,
  parameter int VM_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        ch,
  input  logic              en_0,
  input  logic [VM_W-1:0]   vm,
  input  logic [VM_W-1:0]   vref,
  output logic              en_3,
  output logic              Vint_z,
  output logic [N_BITS-1:0] count,
  output logic [N_BITS-1:0] result,
  output logic              result_valid,
  output logic              overflow
);

  localparam int AW = VM_W + N_BITS;
  localparam logic [N_BITS-1:0] CNT_MAX = {N_BITS{1'b1}};

  logic              sel_zr_s, sel_ref_s, sel_vm_s;
  logic [VM_W-1:0]   vref_eff_s;
  logic [AW-1:0]     vref_ext_s;
  logic [AW:0]       sum_s;
  logic              cnt_max_s, vint_zero_s, conv_end_s, ovf_hit_s;

  logic [AW-1:0]     vint_q, vint_d;
  logic [N_BITS-1:0] cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [N_BITS-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              overflow_q, overflow_d;

  // Switch decode, status outputs and all next-state logic.
  always_comb begin
    sel_zr_s    = ch[2];
    sel_ref_s   = ch[1] & ~ch[2];
    sel_vm_s    = ch[0] & ~ch[1] & ~ch[2];
    vref_eff_s  = (vref == {VM_W{1'b0}}) ? {{(VM_W-1){1'b0}}, 1'b1} : vref;
    vref_ext_s  = {{N_BITS{1'b0}}, vref_eff_s};
    sum_s       = {1'b0, vint_q} + {{(N_BITS+1){1'b0}}, vm};
    cnt_max_s   = (cnt_q == CNT_MAX);
    vint_zero_s = sel_ref_s & (vint_q == {AW{1'b0}});
    conv_end_s  = en_0 & vint_zero_s;
    ovf_hit_s   = en_0 & sel_ref_s & cnt_max_s & (vint_q != {AW{1'b0}});

    en_3   = ~reset & en_0 & sel_vm_s & cnt_max_s;
    Vint_z = ~reset & vint_zero_s;

    vint_d = vint_q;
    if (sel_zr_s) begin
      vint_d = {AW{1'b0}};
    end else if (sel_ref_s) begin
      // Clamp at zero rather than wrapping; the residue below vref is discarded.
      vint_d = (vint_q > vref_ext_s) ? (vint_q - vref_ext_s) : {AW{1'b0}};
    end else if (sel_vm_s) begin
      vint_d = sum_s[AW] ? {AW{1'b1}} : sum_s[AW-1:0];
    end else begin
      vint_d = vint_q;
    end

    cnt_d = en_0 ? (cnt_q + N_BITS'(1)) : {N_BITS{1'b0}};

    ovf_pend_d = ovf_pend_q;
    if (sel_vm_s) begin
      ovf_pend_d = 1'b0;
    end else if (ovf_hit_s) begin
      ovf_pend_d = 1'b1;
    end else begin
      ovf_pend_d = ovf_pend_q;
    end

    result_d       = result_q;
    overflow_d     = overflow_q;
    result_valid_d = 1'b0;
    if (conv_end_s) begin
      result_d       = ovf_pend_q ? CNT_MAX : cnt_q;
      overflow_d     = ovf_pend_q;
      result_valid_d = 1'b1;
    end else begin
      result_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vint_q         <= {AW{1'b0}};
      cnt_q          <= {N_BITS{1'b0}};
      ovf_pend_q     <= 1'b0;
      result_q       <= {N_BITS{1'b0}};
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      vint_q         <= vint_d;
      cnt_q          <= cnt_d;
      ovf_pend_q     <= ovf_pend_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign count        = reset ? {N_BITS{1'b0}} : cnt_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_dual_slope_datapath.sv
// Self-checking bench for dual_slope_datapath: directed and random conversions
// compared against ceil(16*vm/vref) computed arithmetically.
module tb_dual_slope_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] ch;
  logic       en_0;
  logic [7:0] vm, vref;
  logic       en_3, Vint_z;
  logic [3:0] count, result;
  logic       result_valid, overflow;

  int checks = 0;
  int failures = 0;

  dual_slope_datapath #(.N_BITS(4), .VM_W(8)) dut (
    .clk(clk), .reset(reset), .ch(ch), .en_0(en_0), .vm(vm), .vref(vref),
    .en_3(en_3), .Vint_z(Vint_z), .count(count), .result(result),
    .result_valid(result_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_conv(input int vm_i, input int vref_i);
    int vref_e, k, exp_res, exp_ovf, edges, early;
    vref_e  = (vref_i == 0) ? 1 : vref_i;
    k       = (16 * vm_i + vref_e - 1) / vref_e;
    exp_ovf = (k > 15) ? 1 : 0;
    exp_res = exp_ovf ? 15 : k;

    vm = 8'(vm_i); vref = 8'(vref_i);
    en_0 = 1'b0; ch = 3'b100;
    tick();
    ch = 3'b001; en_0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk_eq("en_3_integrate", {31'b0, en_3}, (i == 15) ? 32'd1 : 32'd0);
      tick();
    end
    ch = 3'b010;
    edges = 0;
    early = 0;
    #1;
    while (Vint_z !== 1'b1 && edges < 6000) begin
      if (result_valid) early++;
      tick();
      #1;
      edges++;
    end
    chk_eq("deint_edges", edges, k);
    chk_eq("count_at_zero", {28'b0, count}, k % 16);
    chk_eq("no_early_valid", early, 0);
    tick();
    en_0 = 1'b0; ch = 3'b000;
    #1;
    chk_eq("valid_pulse", {31'b0, result_valid}, 1);
    chk_eq("result", {28'b0, result}, exp_res);
    chk_eq("overflow", {31'b0, overflow}, exp_ovf);
    tick();
    #1;
    chk_eq("valid_one_cycle", {31'b0, result_valid}, 0);
    chk_eq("result_hold", {28'b0, result}, exp_res);
  endtask

  initial begin
    reset = 1'b1; ch = 3'b000; en_0 = 1'b0; vm = 8'd0; vref = 8'd16;
    tick(); tick();

    // Reset while de-integrating with a nonzero integrator.
    reset = 1'b0; vm = 8'd8; ch = 3'b001; en_0 = 1'b1;
    tick(); tick(); tick();
    ch = 3'b010; reset = 1'b1;
    #1;
    chk_eq("rst_en_3", {31'b0, en_3}, 0);
    chk_eq("rst_vint_z", {31'b0, Vint_z}, 0);
    chk_eq("rst_count", {28'b0, count}, 0);
    tick();
    #1;
    chk_eq("rst_result", {28'b0, result}, 0);
    chk_eq("rst_valid", {31'b0, result_valid}, 0);
    chk_eq("rst_overflow", {31'b0, overflow}, 0);
    chk_eq("rst_vint_z_held", {31'b0, Vint_z}, 0);
    reset = 1'b0; en_0 = 1'b0;
    #1;
    chk_eq("post_rst_count", {28'b0, count}, 0);
    chk_eq("post_rst_vint_zero", {31'b0, Vint_z}, 1);
    tick();

    run_conv(8, 16);
    run_conv(5, 16);
    run_conv(3, 7);
    run_conv(16, 16);
    run_conv(4, 16);
    run_conv(0, 16);
    run_conv(15, 16);
    run_conv(1, 0);

    // ch_zr must win over ch_ref.
    vm = 8'd200; en_0 = 1'b0; ch = 3'b100;
    tick();
    ch = 3'b001;
    tick(); tick(); tick();
    ch = 3'b110;
    tick();
    ch = 3'b010;
    #1;
    chk_eq("zr_priority", {31'b0, Vint_z}, 1);
    ch = 3'b000;
    tick();

    for (int r = 0; r < 8; r++) begin
      run_conv(int'($urandom_range(0, 255)), int'($urandom_range(1, 255)));
    end

    // Reset mid de-integrate: no pulse, result cleared, integrator cleared.
    run_conv(8, 16);
    vm = 8'd8; vref = 8'd16; ch = 3'b100; en_0 = 1'b0;
    tick();
    ch = 3'b001; en_0 = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    ch = 3'b010;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    #1;
    chk_eq("midrst_valid", {31'b0, result_valid}, 0);
    chk_eq("midrst_result", {28'b0, result}, 0);
    reset = 1'b0; en_0 = 1'b0;
    #1;
    chk_eq("midrst_vint_zero", {31'b0, Vint_z}, 1);
    ch = 3'b000;
    tick();
    #1;
    chk_eq("midrst_no_pulse", {31'b0, result_valid}, 0);
    run_conv(8, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
